adder_rpn_ctrl: RTL and testbench

Sequencing controller for the 4-bit adder/subtractor datapath. It parses an ASCII character stream from the UART receiver in reverse-Polish order (operand, operand, operator) and loads the adder operand registers. It issues a one-cycle start with the add/subtract select, waits for the adder's ready with a timeout, and returns the 5-bit result to the UART transmitter as ASCII over a valid/ready handshake. It sits between the UART RX/TX blocks and the adder.

---
 rtl/adder_ctrl_pkg.sv | 40 ++++
 rtl/adder_rpn_ctrl_if.sv | 29 ++
 rtl/ascii_hex_decode.sv | 23 ++
 rtl/adder_rpn_ctrl.sv | 150 +++++++++++++++
 tb/tb_adder_rpn_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the RPN adder controller: state encoding,
// ASCII codes and the nibble-to-hex formatter.
package adder_ctrl_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SUM_W   = 5;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 8;

    // Encodings are visible on o_state and must not change
    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_HAVE1   = 3'd1,
        S_HAVE2   = 3'd2,
        S_START   = 3'd3,
        S_WAIT    = 3'd4,
        S_EMIT_HI = 3'd5,
        S_EMIT_LO = 3'd6,
        S_EMIT_NL = 3'd7
    } state_t;

    localparam logic [DATA_W-1:0] ASCII_PLUS  = 8'h2B;
    localparam logic [DATA_W-1:0] ASCII_MINUS = 8'h2D;
    localparam logic [DATA_W-1:0] ASCII_X_LO  = 8'h78;
    localparam logic [DATA_W-1:0] ASCII_X_UP  = 8'h58;
    localparam logic [DATA_W-1:0] ASCII_ESC   = 8'h1B;
    localparam logic [DATA_W-1:0] ASCII_LF    = 8'h0A;
    localparam logic [DATA_W-1:0] ASCII_QMARK = 8'h3F;
    localparam logic [DATA_W-1:0] ASCII_ZERO  = 8'h30;
    localparam logic [DATA_W-1:0] ASCII_ONE   = 8'h31;

    function automatic logic [DATA_W-1:0] nibble_to_ascii(input logic [NIB_W-1:0] n);
        if (n < 4'd10)
            return 8'(ASCII_ZERO + {4'h0, n});
        else
            return 8'(8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/adder_rpn_ctrl_if.sv
// Bundle of the UART RX, adder and UART TX signals seen by the RPN controller.
interface adder_rpn_ctrl_if;
    import adder_ctrl_pkg::*;

    logic [DATA_W-1:0]  i_rx_data;
    logic               i_rx_valid;
    logic [NIB_W-1:0]   o_r1;
    logic [NIB_W-1:0]   o_r2;
    logic               o_subtract;
    logic               o_start;
    logic [SUM_W-1:0]   i_sum;
    logic               i_rdy;
    logic [DATA_W-1:0]  o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;
    logic               o_err;
    logic [STATE_W-1:0] o_state;

    modport master (
        input  i_rx_data, i_rx_valid, i_sum, i_rdy, i_tx_ready,
        output o_r1, o_r2, o_subtract, o_start, o_tx_data, o_tx_valid, o_err, o_state
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_sum, i_rdy, i_tx_ready,
        input  o_r1, o_r2, o_subtract, o_start, o_tx_data, o_tx_valid, o_err, o_state
    );

endinterface

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex-digit classifier: flags 0-9/A-F/a-f and returns the nibble.
module ascii_hex_decode (
    input  logic [7:0] i_byte,
    output logic       o_is_hex_c,
    output logic [3:0] o_value_c
);

    always_comb begin
        o_is_hex_c = 1'b0;
        o_value_c  = 4'h0;
        if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
            o_is_hex_c = 1'b1;
            o_value_c  = 4'(i_byte - 8'h30);
        end else if (i_byte >= 8'h41 && i_byte <= 8'h46) begin
            o_is_hex_c = 1'b1;
            o_value_c  = 4'(i_byte - 8'h37);
        end else if (i_byte >= 8'h61 && i_byte <= 8'h66) begin
            o_is_hex_c = 1'b1;
            o_value_c  = 4'(i_byte - 8'h57);
        end
    end

endmodule

// File: rtl/adder_rpn_ctrl.sv
// RPN sequencing controller: parses operand/operand/operator from the UART RX
// stream, runs the adder with a timeout and prints the result as ASCII.
module adder_rpn_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk_in,
    input  logic             i_rst,
    adder_rpn_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [NIB_W-1:0]  r_r1;
    logic [NIB_W-1:0]  r_r2;
    logic              r_sub;
    logic              r_start;
    logic [NIB_W-1:0]  r_res_lo;
    logic              r_abort;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_err;

    logic              w_is_hex;
    logic [NIB_W-1:0]  w_hex_val;
    logic              w_is_op;
    logic              w_is_clr;
    logic              w_busy;

    ascii_hex_decode u_dec (
        .i_byte     (bus.i_rx_data),
        .o_is_hex_c (w_is_hex),
        .o_value_c  (w_hex_val)
    );

    assign w_is_op  = (bus.i_rx_data == ASCII_PLUS) || (bus.i_rx_data == ASCII_MINUS);
    assign w_is_clr = (bus.i_rx_data == ASCII_X_LO) || (bus.i_rx_data == ASCII_X_UP) ||
                      (bus.i_rx_data == ASCII_ESC);
    assign w_busy   = (r_state != S_IDLE) && (r_state != S_HAVE1) && (r_state != S_HAVE2);

    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_r1       <= '0;
            r_r2       <= '0;
            r_sub      <= 1'b0;
            r_start    <= 1'b0;
            r_res_lo   <= '0;
            r_abort    <= 1'b0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_err   <= 1'b0;
            // Bytes arriving while an operation is in flight are dropped
            if (bus.i_rx_valid && w_busy)
                r_err <= 1'b1;

            case (r_state)
                S_IDLE, S_HAVE1, S_HAVE2: begin
                    if (bus.i_rx_valid) begin
                        if (w_is_hex) begin
                            if (r_state == S_IDLE) begin
                                r_r1    <= w_hex_val;
                                r_state <= S_HAVE1;
                            end else if (r_state == S_HAVE1) begin
                                r_r2    <= w_hex_val;
                                r_state <= S_HAVE2;
                            end else begin
                                r_r1 <= r_r2;
                                r_r2 <= w_hex_val;
                            end
                        end else if (w_is_op) begin
                            if (r_state == S_HAVE2) begin
                                r_sub   <= (bus.i_rx_data == ASCII_MINUS);
                                r_start <= 1'b1;
                                r_state <= S_START;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (w_is_clr) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_abort <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Adder ready takes priority over a coincident timeout
                    if (bus.i_rdy) begin
                        r_res_lo   <= bus.i_sum[NIB_W-1:0];
                        r_abort    <= 1'b0;
                        r_tx_data  <= bus.i_sum[SUM_W-1] ? ASCII_ONE : ASCII_ZERO;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_EMIT_HI;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_abort    <= 1'b1;
                        r_tx_data  <= ASCII_QMARK;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_EMIT_HI;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_EMIT_HI: begin
                    if (bus.i_tx_ready) begin
                        if (r_abort) begin
                            r_tx_data <= ASCII_LF;
                            r_state   <= S_EMIT_NL;
                        end else begin
                            r_tx_data <= nibble_to_ascii(r_res_lo);
                            r_state   <= S_EMIT_LO;
                        end
                    end
                end
                S_EMIT_LO: begin
                    if (bus.i_tx_ready) begin
                        r_tx_data <= ASCII_LF;
                        r_state   <= S_EMIT_NL;
                    end
                end
                S_EMIT_NL: begin
                    if (bus.i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_r1       = r_r1;
    assign bus.o_r2       = r_r2;
    assign bus.o_subtract = r_sub;
    assign bus.o_start    = r_start;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_valid = r_tx_valid;
    assign bus.o_err      = r_err;
    assign bus.o_state    = r_state;

endmodule

// File: tb/tb_adder_rpn_ctrl.sv
// Scoreboard bench for adder_rpn_ctrl: a byte-level RPN model predicts start
// events, TX bytes, first-byte latency and error pulses; a monitor checks them.
module tb_adder_rpn_ctrl;

    logic clk_in = 1'b0;
    logic i_rst  = 1'b0;
    always #5 clk_in = ~clk_in;

    adder_rpn_ctrl_if bus();

    adder_rpn_ctrl #(.TIMEOUT(15)) dut (
        .clk_in (clk_in),
        .i_rst  (i_rst),
        .bus    (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [8:0] q_start[$];
    logic [7:0] q_tx[$];
    int         q_lat[$];

    int         m_n;
    logic [3:0] m_r1, m_r2;
    bit         m_busy;
    int         exp_err = 0;
    int         obs_err = 0;
    int         lat = 2;
    int         ready_mode = 1;   // 0 low, 1 high, 2 random

    string hx = "0123456789ABCDEF";
    string digits = "0123456789ABCDEFabcdef";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int hex_val(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
        return -1;
    endfunction

    // Reference behaviour of one received byte
    task automatic model_byte(input logic [7:0] b);
        int v, r;
        bit sub;
        v = hex_val(b);
        if (m_busy) begin
            exp_err++;
        end else if (v >= 0) begin
            if (m_n == 0) begin m_r1 = 4'(v); m_n = 1; end
            else if (m_n == 1) begin m_r2 = 4'(v); m_n = 2; end
            else begin m_r1 = m_r2; m_r2 = 4'(v); end
        end else if (b == 8'h2B || b == 8'h2D) begin
            if (m_n == 2) begin
                sub = (b == 8'h2D);
                q_start.push_back({m_r1, m_r2, sub});
                r = sub ? int'(m_r1) + 16 - int'(m_r2) : int'(m_r1) + int'(m_r2);
                if (lat >= 1 && lat <= 15) begin
                    q_tx.push_back(r >= 16 ? 8'h31 : 8'h30);
                    q_tx.push_back(hx[r % 16]);
                    q_lat.push_back(lat + 1);
                end else begin
                    q_tx.push_back(8'h3F);
                    q_lat.push_back(16);
                end
                q_tx.push_back(8'h0A);
                m_busy = 1'b1;
                m_n = 0;
            end else begin
                exp_err++;
            end
        end else if (b == 8'h78 || b == 8'h58 || b == 8'h1B) begin
            m_n = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        model_byte(b);
        @(negedge clk_in);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(bus.o_state == 3'd0 && q_tx.size() == 0) && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        @(negedge clk_in); #1;
        check({name, "_done"}, 32'(bus.o_state == 3'd0 && q_tx.size() == 0), 1);
        m_busy = 1'b0;
        check({name, "_r1"}, bus.o_r1, m_r1);
        check({name, "_r2"}, bus.o_r2, m_r2);
        check({name, "_errs"}, obs_err, exp_err);
    endtask

    task automatic wait_tx_valid();
        int n = 0;
        while (!bus.o_tx_valid && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        check("tx_valid_seen", bus.o_tx_valid, 1);
    endtask

    task automatic model_reset();
        q_start.delete(); q_tx.delete(); q_lat.delete();
        m_n = 0; m_r1 = 4'h0; m_r2 = 4'h0; m_busy = 1'b0;
    endtask

    // TX ready driver, changes away from both edges
    initial begin
        bus.i_tx_ready = 1'b1;
        forever begin
            @(posedge clk_in); #1;
            case (ready_mode)
                0:       bus.i_tx_ready = 1'b0;
                1:       bus.i_tx_ready = 1'b1;
                default: bus.i_tx_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Adder model: answers `lat` cycles after start; lat 0 never answers
    initial begin
        int l;
        logic [4:0] s;
        bus.i_rdy = 1'b0;
        bus.i_sum = 5'h0;
        forever begin
            @(negedge clk_in);
            bus.i_sum = 5'($urandom);
            if (bus.o_start && i_rst) begin
                l = lat;
                s = bus.o_subtract ? 5'({1'b0, bus.o_r1} + 5'd16 - {1'b0, bus.o_r2})
                                   : 5'({1'b0, bus.o_r1} + {1'b0, bus.o_r2});
                if (l > 0) begin
                    repeat (l - 1) begin
                        @(negedge clk_in);
                        bus.i_sum = 5'($urandom);
                    end
                    @(negedge clk_in);
                    bus.i_rdy = 1'b1;
                    bus.i_sum = s;
                    @(negedge clk_in);
                    bus.i_rdy = 1'b0;
                    bus.i_sum = 5'($urandom);
                end
            end
        end
    end

    // Monitor
    initial begin
        bit pv, pr, ps, expect_first;
        logic [7:0] pd;
        int cyc, start_cyc;
        pv = 0; pr = 0; ps = 0; expect_first = 0; pd = 8'h0; cyc = 0; start_cyc = 0;
        forever begin
            @(negedge clk_in);
            if (!i_rst) begin
                pv = 0; ps = 0; expect_first = 0;
                continue;
            end
            cyc++;
            if (bus.o_start) begin
                check("start_pulse_width", 32'(ps), 0);
                check("start_expected", 32'(q_start.size() > 0), 1);
                if (q_start.size() > 0)
                    check("start_operands", {bus.o_r1, bus.o_r2, bus.o_subtract}, q_start.pop_front());
                start_cyc = cyc;
                expect_first = 1;
            end
            if (bus.o_err) obs_err++;
            if (pv && !pr) begin
                check("tx_hold_valid", bus.o_tx_valid, 1);
                check("tx_hold_data", bus.o_tx_data, pd);
            end
            if (expect_first && bus.o_tx_valid) begin
                if (q_lat.size() > 0) check("tx_latency", cyc - start_cyc, q_lat.pop_front());
                expect_first = 0;
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                check("tx_expected", 32'(q_tx.size() > 0), 1);
                if (q_tx.size() > 0) check("tx_byte", bus.o_tx_data, q_tx.pop_front());
            end
            pv = bus.o_tx_valid; pr = bus.i_tx_ready; pd = bus.o_tx_data; ps = bus.o_start;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int nd, k;
        logic [7:0] fill[4] = '{8'h20, 8'h0D, 8'h0A, 8'h67};
        bus.i_rx_data = 8'h0;
        bus.i_rx_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check("reset_outputs", {bus.o_r1, bus.o_r2, bus.o_subtract, bus.o_start,
                                bus.o_tx_data, bus.o_tx_valid, bus.o_err}, 0);
        check("reset_state", bus.o_state, 0);
        #2 i_rst = 1'b1;
        @(negedge clk_in);

        lat = 2; send("4"); send("5"); send("+"); wait_idle("add_4_5");
        lat = 2; send("7"); send("9"); send("-"); wait_idle("sub_7_9");

        // Transmitter stalled for 10 cycles on the first byte
        ready_mode = 0; lat = 2;
        send("F"); send("F"); send("+");
        wait_tx_valid();
        repeat (10) @(negedge clk_in);
        check("stall_hi_byte", bus.o_tx_data, 8'h31);
        ready_mode = 1;
        wait_idle("add_F_F_stall");

        lat = 3; send("1"); send("2"); send("3"); send("+"); wait_idle("shift_123");
        send("3"); send("+");
        @(negedge clk_in); #1;
        check("op_in_have1_state", bus.o_state, 1);
        check("op_in_have1_err", obs_err, exp_err);
        send("x");
        #1 check("clear_to_idle", bus.o_state, 0);

        lat = 0;  send("A"); send("6"); send("+"); wait_idle("timeout");
        lat = 15; send("A"); send("6"); send("-"); wait_idle("rdy_at_timeout");
        lat = 14; send("3"); send("C"); send("+"); wait_idle("rdy_before_timeout");
        lat = 16; send("3"); send("C"); send("-"); wait_idle("rdy_after_timeout");

        lat = 4; send("2"); send("3"); send("-");
        send("5"); send("6"); send("+");
        wait_idle("busy_bytes");

        // Reset while the low nibble is being presented
        ready_mode = 0; lat = 2;
        send("C"); send("4"); send("+");
        wait_tx_valid();
        ready_mode = 1;
        @(negedge clk_in);
        ready_mode = 0;
        @(negedge clk_in);
        check("pre_reset_state", bus.o_state, 6);
        #2 i_rst = 1'b0;
        #1 check("async_reset_outputs", {bus.o_r1, bus.o_r2, bus.o_subtract, bus.o_start,
                                         bus.o_tx_data, bus.o_tx_valid, bus.o_err, bus.o_state}, 0);
        model_reset();
        repeat (3) @(negedge clk_in);
        #2 i_rst = 1'b1;
        ready_mode = 1;
        @(negedge clk_in);
        repeat (5) @(negedge clk_in);
        lat = 2; send("8"); send("1"); send("+"); wait_idle("after_reset");

        for (int op = 0; op < 25; op++) begin
            ready_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
            lat = $urandom_range(0, 17);
            if ($urandom_range(0, 3) == 0) begin
                send(digits[$urandom_range(0, 21)]);
                send("+");
                send(($urandom_range(0, 1) == 0) ? 8'h1B : 8'h58);
            end
            nd = $urandom_range(2, 4);
            for (int d = 0; d < nd; d++) begin
                if ($urandom_range(0, 2) == 0) send(fill[$urandom_range(0, 3)]);
                send(digits[$urandom_range(0, 21)]);
            end
            send(($urandom_range(0, 1) == 0) ? 8'h2B : 8'h2D);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) send(8'($urandom));
            wait_idle("random_op");
        end

        check("final_err_count", obs_err, exp_err);
        check("final_queues_empty", 32'(q_start.size() + q_tx.size() + q_lat.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
